// File: rtl/ace_snoop_initiator_if.sv
// ace_snoop_initiator_if: request/response and AC/CR/CD snoop signals of the
// snoop initiator. The slave modport is the initiator, and the master modport
// is the environment (coherency controller plus the snooped caches).
interface ace_snoop_initiator_if #(
  parameter int NrPorts   = 2,
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int LineBeats = 2
);
  logic                           req_valid_i;
  logic                           req_ready_o;
  logic [AddrWidth-1:0]           req_addr_i;
  logic [3:0]                     req_snoop_i;
  logic [NrPorts-1:0]             req_exclude_i;
  logic                           resp_valid_o;
  logic                           resp_ready_i;
  logic [LineBeats*DataWidth-1:0] resp_data_o;
  logic                           resp_has_data_o;
  logic                           resp_dirty_o;
  logic                           resp_shared_o;
  logic                           resp_error_o;
  logic [NrPorts-1:0]             ac_valid_o;
  logic [NrPorts-1:0]             ac_ready_i;
  logic [AddrWidth-1:0]           ac_addr_o;
  logic [3:0]                     ac_snoop_o;
  logic [NrPorts-1:0]             cr_valid_i;
  logic [NrPorts-1:0]             cr_ready_o;
  logic [NrPorts*5-1:0]           cr_resp_i;
  logic [NrPorts-1:0]             cd_valid_i;
  logic [NrPorts-1:0]             cd_ready_o;
  logic [NrPorts*DataWidth-1:0]   cd_data_i;
  logic [NrPorts-1:0]             cd_last_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_snoop_i, req_exclude_i, resp_ready_i,
           ac_ready_i, cr_valid_i, cr_resp_i, cd_valid_i, cd_data_i, cd_last_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_has_data_o, resp_dirty_o,
           resp_shared_o, resp_error_o, ac_valid_o, ac_addr_o, ac_snoop_o,
           cr_ready_o, cd_ready_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_snoop_i, req_exclude_i, resp_ready_i,
           ac_ready_i, cr_valid_i, cr_resp_i, cd_valid_i, cd_data_i, cd_last_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_has_data_o, resp_dirty_o,
           resp_shared_o, resp_error_o, ac_valid_o, ac_addr_o, ac_snoop_o,
           cr_ready_o, cd_ready_o
  );
endinterface

// File: rtl/ace_snoop_initiator.sv
// ace_snoop_initiator: broadcasts one snoop at a time to all non-excluded
// caches, merges their CR responses, captures one line from the lowest-index
// data-transferring cache and returns the merged result upstream.
// Optional watchdog: define SNOOP_TIMEOUT_EN to abort a stuck snoop after
// TimeoutCycles cycles with an error result.
module ace_snoop_initiator #(
  parameter int NrPorts       = 2,
  parameter int AddrWidth     = 64,
  parameter int DataWidth     = 64,
  parameter int LineBeats     = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ace_snoop_initiator_if.slave  bus
);
  localparam int BeatW = $clog2(LineBeats);

  typedef enum logic [2:0] {IDLE, SEND_AC, WAIT_CR, WAIT_CD, RESP} state_e;

  state_e                         r_state, w_state_nxt;
  logic [AddrWidth-1:0]           r_addr;
  logic [3:0]                     r_snoop;
  logic [NrPorts-1:0]             r_pend, r_ac_done, r_cr_done, r_dt, r_cd_done;
  logic [BeatW-1:0]               r_beat;
  logic [LineBeats*DataWidth-1:0] r_line;
  logic                           r_has_data, r_dirty, r_shared, r_error;

  logic [NrPorts-1:0]   w_ac_hs, w_cr_hs, w_cd_hs, w_cd_done_set;
  logic [NrPorts-1:0]   w_cr_dt, w_cr_err, w_cr_dirty, w_cr_shared, w_cr_wu;
  logic [NrPorts-1:0]   w_sel_oh, w_dt_nxt;
  logic [DataWidth-1:0] w_sel_data;
  logic                 w_sel_last, w_sel_hs, w_sel_final, w_sel_err;
  logic                 w_ac_all, w_cr_all, w_cd_all, w_tmo, w_active;
  logic                 w_unused;

  assign w_ac_hs = bus.ac_valid_o & bus.ac_ready_i;
  assign w_cr_hs = bus.cr_valid_i & bus.cr_ready_o;
  assign w_cd_hs = bus.cd_valid_i & bus.cd_ready_o;
  // Lowest set bit of the data-transfer mask picks the port whose line is kept.
  assign w_sel_oh = r_dt & (~r_dt + NrPorts'(1));
  assign w_active = (r_state == SEND_AC) || (r_state == WAIT_CR) || (r_state == WAIT_CD);

  // Split the packed CR fields and mux the selected port's CD beat.
  always_comb begin
    w_cr_dt     = '0;
    w_cr_err    = '0;
    w_cr_dirty  = '0;
    w_cr_shared = '0;
    w_cr_wu     = '0;
    w_sel_data  = '0;
    w_sel_last  = 1'b0;
    for (int i = 0; i < NrPorts; i++) begin
      w_cr_dt[i]     = bus.cr_resp_i[i*5+0];
      w_cr_err[i]    = bus.cr_resp_i[i*5+1];
      w_cr_dirty[i]  = bus.cr_resp_i[i*5+2];
      w_cr_shared[i] = bus.cr_resp_i[i*5+3];
      w_cr_wu[i]     = bus.cr_resp_i[i*5+4];
      if (w_sel_oh[i]) begin
        w_sel_data = w_sel_data | bus.cd_data_i[i*DataWidth +: DataWidth];
        w_sel_last = w_sel_last | bus.cd_last_i[i];
      end
    end
  end

  // The selected port must end its burst exactly on the last beat of the line;
  // ending early or overrunning both terminate that port with an error.
  assign w_sel_hs      = |(w_cd_hs & w_sel_oh);
  assign w_sel_final   = (r_beat == BeatW'(LineBeats - 1));
  assign w_sel_err     = w_sel_hs && (w_sel_last != w_sel_final);
  assign w_cd_done_set = (w_cd_hs & bus.cd_last_i) |
                         (w_sel_oh & {NrPorts{w_sel_hs && w_sel_final}});

  assign w_ac_all = ((r_ac_done | w_ac_hs) == r_pend);
  assign w_cr_all = ((r_cr_done | w_cr_hs) == r_pend);
  assign w_dt_nxt = r_dt | (w_cr_hs & w_cr_dt);
  assign w_cd_all = ((r_cd_done | w_cd_done_set) == r_dt);

`ifdef SNOOP_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] r_cnt;

  // Elapsed cycles since accept, with the accept cycle counted as the first.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                                   r_cnt <= '0;
    else if (r_state == IDLE && bus.req_valid_i)   r_cnt <= CntW'(1);
    else if (w_active)                             r_cnt <= r_cnt + CntW'(1);
  end

  assign w_tmo = w_active && (r_cnt == CntW'(TimeoutCycles - 1));
`else
  assign w_tmo = 1'b0;
`endif

  assign w_unused = ^w_cr_wu ^ (TimeoutCycles > 0);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; the watchdog masks every handshake.
  always_comb begin
    w_state_nxt      = r_state;
    bus.req_ready_o  = 1'b0;
    bus.resp_valid_o = 1'b0;
    bus.ac_valid_o   = '0;
    bus.cr_ready_o   = '0;
    bus.cd_ready_o   = '0;
    case (r_state)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) w_state_nxt = (&bus.req_exclude_i) ? RESP : SEND_AC;
      end
      SEND_AC: begin
        bus.ac_valid_o = w_tmo ? '0 : (r_pend & ~r_ac_done);
        bus.cr_ready_o = w_tmo ? '0 : (r_ac_done & ~r_cr_done);
        if (w_tmo)         w_state_nxt = RESP;
        else if (w_ac_all) w_state_nxt = WAIT_CR;
      end
      WAIT_CR: begin
        bus.cr_ready_o = w_tmo ? '0 : (r_ac_done & ~r_cr_done);
        if (w_tmo)         w_state_nxt = RESP;
        else if (w_cr_all) w_state_nxt = (|w_dt_nxt) ? WAIT_CD : RESP;
      end
      WAIT_CD: begin
        bus.cd_ready_o = w_tmo ? '0 : (r_dt & ~r_cd_done);
        if (w_tmo || w_cd_all) w_state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid_o = 1'b1;
        if (bus.resp_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request capture, response accumulation and line buffer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_addr <= '0; r_snoop <= '0; r_pend <= '0; r_ac_done <= '0; r_cr_done <= '0;
      r_dt <= '0; r_cd_done <= '0; r_beat <= '0; r_line <= '0;
      r_has_data <= 1'b0; r_dirty <= 1'b0; r_shared <= 1'b0; r_error <= 1'b0;
    end else if (r_state == IDLE) begin
      if (bus.req_valid_i) begin
        r_addr <= bus.req_addr_i; r_snoop <= bus.req_snoop_i; r_pend <= ~bus.req_exclude_i;
        r_ac_done <= '0; r_cr_done <= '0; r_dt <= '0; r_cd_done <= '0; r_beat <= '0;
        r_line <= '0; r_has_data <= 1'b0; r_dirty <= 1'b0; r_shared <= 1'b0; r_error <= 1'b0;
      end
    end else begin
      r_ac_done <= r_ac_done | w_ac_hs;
      r_cr_done <= r_cr_done | w_cr_hs;
      r_dt      <= w_dt_nxt;
      r_cd_done <= r_cd_done | w_cd_done_set;
      r_shared  <= r_shared | (|(w_cr_hs & w_cr_shared));
      r_dirty   <= r_dirty  | (|(w_cr_hs & w_cr_dirty));
      r_error   <= r_error  | (|(w_cr_hs & w_cr_err)) | w_sel_err | w_tmo;
      if (w_sel_hs) begin
        r_line[int'(r_beat)*DataWidth +: DataWidth] <= w_sel_data;
        r_beat <= r_beat + BeatW'(1);
      end
      if (w_tmo)                                       r_has_data <= 1'b0;
      else if (r_state == WAIT_CD && w_cd_all)         r_has_data <= 1'b1;
    end
  end

  assign bus.ac_addr_o       = r_addr;
  assign bus.ac_snoop_o      = r_snoop;
  assign bus.resp_data_o     = r_line;
  assign bus.resp_has_data_o = r_has_data;
  assign bus.resp_dirty_o    = r_dirty;
  assign bus.resp_shared_o   = r_shared;
  assign bus.resp_error_o    = r_error;
endmodule
